// File: rtl/stream_drain_monitor.sv
// rtl/stream_drain_monitor.sv - drains one frame from a FIFO stream with stall patterns, checksum, peak and timeout
module stream_drain_monitor #(
  parameter int WIDTH     = 8,
  parameter int CNTW      = 11,
  parameter int FRAME_LEN = 1600,
  parameter int TIMEOUT   = 4096
) (
  input  logic             ap_clk,
  input  logic             ap_rst,
  input  logic [WIDTH-1:0] in0_V_TDATA,
  input  logic             in0_V_TVALID,
  output logic             in0_V_TREADY,
  input  logic             start,
  input  logic [7:0]       stall_pattern,
  input  logic [CNTW-1:0]  fifo_count,
  output logic [15:0]      beat_count,
  output logic [15:0]      checksum,
  output logic [CNTW-1:0]  peak_count,
  output logic             done,
  output logic             frame_err,
  output logic             busy
);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

  localparam int IDLEW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam int SUMW  = (WIDTH > 16) ? WIDTH : 16;
  localparam logic [IDLEW-1:0] IDLE_LAST = IDLEW'(TIMEOUT - 1);
  localparam logic [15:0]      LAST_BEAT = 16'(FRAME_LEN - 1);

  state_t            r_state;
  logic [2:0]        r_phase;
  logic [IDLEW-1:0]  r_idle;
  logic [15:0]       r_beat_count;
  logic [15:0]       r_checksum;
  logic [CNTW-1:0]   r_peak;
  logic              r_done;
  logic              r_frame_err;

  logic              w_run;
  logic              w_tready;
  logic              w_beat;
  logic [SUMW-1:0]   w_data_ext;
  logic [CNTW-1:0]   w_peak_next;

  assign w_run       = (r_state == ST_RUN);
  assign w_tready    = w_run & stall_pattern[r_phase];
  assign w_beat      = w_tready & in0_V_TVALID;
  // Only the low 16 bits of the data matter for a modulo-2^16 sum.
  assign w_data_ext  = SUMW'(in0_V_TDATA);
  assign w_peak_next = (fifo_count > r_peak) ? fifo_count : r_peak;

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      r_state      <= ST_IDLE;
      r_phase      <= 3'd0;
      r_idle       <= '0;
      r_beat_count <= 16'd0;
      r_checksum   <= 16'd0;
      r_peak       <= '0;
      r_done       <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      case (r_state)
        ST_RUN: begin
          r_phase <= r_phase + 3'd1;
          r_peak  <= w_peak_next;
          // A beat wins over a coincident timeout.
          if (w_beat) begin
            r_beat_count <= r_beat_count + 16'd1;
            r_checksum   <= r_checksum + w_data_ext[15:0];
            r_idle       <= '0;
            if (r_beat_count == LAST_BEAT) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end
          end else if (r_idle == IDLE_LAST) begin
            r_state     <= ST_DONE;
            r_done      <= 1'b1;
            r_frame_err <= 1'b1;
          end else begin
            r_idle <= r_idle + IDLEW'(1);
          end
        end
        default: begin
          if (start) begin
            r_state      <= ST_RUN;
            r_phase      <= 3'd0;
            r_idle       <= '0;
            r_beat_count <= 16'd0;
            r_checksum   <= 16'd0;
            r_peak       <= '0;
            r_done       <= 1'b0;
            r_frame_err  <= 1'b0;
          end
        end
      endcase
    end
  end

  assign in0_V_TREADY = w_tready;
  assign beat_count   = r_beat_count;
  assign checksum     = r_checksum;
  assign peak_count   = r_peak;
  assign done         = r_done;
  assign frame_err    = r_frame_err;
  assign busy         = w_run;

endmodule
